// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchronises and deglitches the phase inputs, then
// turns each accepted Gray-code step into a step/dir pulse and a wrapping position.
module quad_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clear,
  output logic [WIDTH-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int CW = $clog2(FILTER_LEN + 2) + 1;

  typedef enum logic {INIT, TRACK} state_t;

  state_t                 state, next_state;
  logic [SYNC_STAGES-1:0] sync_a, sync_b, sync_vld;
  logic [1:0]             s_ab, p_ab, f_ab;
  logic                   s_vld, p_vld;
  logic [CW-1:0]          cnt;
  logic                   same, held_ok, accept;
  logic                   load, go_up, go_down, go_err;
  logic [1:0]             old_bin, new_bin, delta;

  // sync_vld marks which stages hold real samples, so the zeros left by reset
  // are never mistaken for a stable 00 input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a   <= '0;
      sync_b   <= '0;
      sync_vld <= '0;
    end else begin
      sync_a   <= {sync_a[SYNC_STAGES-2:0], a_in};
      sync_b   <= {sync_b[SYNC_STAGES-2:0], b_in};
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s_ab  = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
  assign s_vld = sync_vld[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      p_ab  <= '0;
      p_vld <= 1'b0;
      cnt   <= '0;
    end else begin
      p_ab  <= s_ab;
      p_vld <= s_vld;
      if (!same)
        cnt <= '0;
      else if (cnt < CW'(FILTER_LEN))
        cnt <= cnt + CW'(1);
    end
  end

  // When s_ab matches the previous cycle it has been stable for cnt+2 cycles.
  always_comb begin
    same    = s_vld & p_vld & (s_ab == p_ab);
    held_ok = 1'b0;
    if (s_vld) begin
      if (same)
        held_ok = ({1'b0, cnt} + (CW+1)'(2)) >= (CW+1)'(FILTER_LEN);
      else
        held_ok = (FILTER_LEN <= 1);
    end
    accept = held_ok & ((state == INIT) | (s_ab != f_ab));
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= INIT;
    else
      state <= next_state;
  end

  // Gray to binary makes the step direction a simple modulo-4 difference.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    go_up      = 1'b0;
    go_down    = 1'b0;
    go_err     = 1'b0;
    old_bin    = {f_ab[1], f_ab[1] ^ f_ab[0]};
    new_bin    = {s_ab[1], s_ab[1] ^ s_ab[0]};
    delta      = new_bin - old_bin;
    case (state)
      INIT: begin
        if (accept) begin
          load       = 1'b1;
          next_state = TRACK;
        end
      end
      TRACK: begin
        if (accept) begin
          load    = 1'b1;
          go_up   = (delta == 2'd1);
          go_down = (delta == 2'd3);
          go_err  = (delta == 2'd2);
        end
      end
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_ab <= '0;
      pos  <= '0;
      dir  <= 1'b0;
      step <= 1'b0;
      err  <= 1'b0;
    end else begin
      step <= go_up | go_down;
      err  <= go_err;
      if (load)
        f_ab <= s_ab;
      if (go_up)
        dir <= 1'b1;
      else if (go_down)
        dir <= 1'b0;
      if (clear)
        pos <= '0;
      else if (go_up)
        pos <= pos + WIDTH'(1);
      else if (go_down)
        pos <= pos - WIDTH'(1);
    end
  end

endmodule
